// File: rtl/ysyx_22050710_wb_stage.sv
// Write-back stage: registers the memory-stage bus, drives the GPR/CSR write ports, the decode
// bypass bus, the commit trace and the retired-instruction counter.
module ysyx_22050710_wb_stage #(
  parameter int unsigned WORD_WD         = 64,
  parameter int unsigned PC_WD           = 64,
  parameter int unsigned INST_WD         = 32,
  parameter int unsigned GPR_ADDR_WD     = 5,
  parameter int unsigned CSR_ADDR_WD     = 12,
  parameter int unsigned MS_TO_WS_BUS_WD = 147,
  parameter int unsigned BYPASS_BUS_WD   = 145,
  parameter int unsigned DEBUG_BUS_WD    = 227
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_ws_allowin,
  input  logic                       i_ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] i_ms_to_ws_bus,
  input  logic [DEBUG_BUS_WD-1:0]    i_debug_ms_to_ws_bus,
  input  logic                       i_commit_stall,
  output logic                       o_gpr_wen,
  output logic [GPR_ADDR_WD-1:0]     o_gpr_waddr,
  output logic [WORD_WD-1:0]         o_gpr_wdata,
  output logic                       o_csr_wen,
  output logic [CSR_ADDR_WD-1:0]     o_csr_waddr,
  output logic [WORD_WD-1:0]         o_csr_wdata,
  output logic [BYPASS_BUS_WD-1:0]   o_ws_to_ds_bypass_bus,
  output logic                       o_debug_commit,
  output logic [PC_WD-1:0]           o_debug_pc,
  output logic [PC_WD-1:0]           o_debug_dnpc,
  output logic [INST_WD-1:0]         o_debug_inst,
  output logic                       o_debug_memen,
  output logic [WORD_WD-1:0]         o_debug_memaddr,
  output logic [63:0]                o_retire_cnt
);

  typedef struct packed {
    logic                   gpr_wen;
    logic [GPR_ADDR_WD-1:0] rd;
    logic [WORD_WD-1:0]     gpr_result;
    logic                   csr_wen;
    logic [CSR_ADDR_WD-1:0] csr;
    logic [WORD_WD-1:0]     csr_result;
  } ms_bus_t;

  typedef struct packed {
    logic               valid;
    logic               addnop;
    logic [INST_WD-1:0] inst;
    logic [PC_WD-1:0]   pc;
    logic [PC_WD-1:0]   dnpc;
    logic               memen;
    logic [WORD_WD-1:0] memaddr;
  } dbg_bus_t;

  logic     ws_valid_q;
  ms_bus_t  ms_bus_q;
  dbg_bus_t dbg_bus_q;
  logic [63:0] retire_cnt_q;

  logic ws_ready_go;
  logic ws_allowin;
  logic fire;
  logic commit;

  assign ws_ready_go = !i_commit_stall;
  // Last stage: nothing downstream can refuse, only the environment stall.
  assign ws_allowin  = !ws_valid_q || ws_ready_go;
  assign fire        = ws_valid_q && ws_ready_go;
  assign commit      = fire && dbg_bus_q.valid && !dbg_bus_q.addnop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ws_valid_q   <= 1'b0;
      ms_bus_q     <= '0;
      dbg_bus_q    <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (ws_allowin) begin
        ws_valid_q <= i_ms_to_ws_valid;
      end
      if (ws_allowin && i_ms_to_ws_valid) begin
        ms_bus_q  <= i_ms_to_ws_bus;
        dbg_bus_q <= i_debug_ms_to_ws_bus;
      end
      if (commit) begin
        retire_cnt_q <= retire_cnt_q + 64'd1;
      end
    end
  end

  always_comb begin
    o_ws_allowin    = ws_allowin;
    o_gpr_wen       = fire && ms_bus_q.gpr_wen && (ms_bus_q.rd != '0);
    o_gpr_waddr     = ms_bus_q.rd;
    o_gpr_wdata     = ms_bus_q.gpr_result;
    o_csr_wen       = fire && ms_bus_q.csr_wen;
    o_csr_waddr     = ms_bus_q.csr;
    o_csr_wdata     = ms_bus_q.csr_result;
    o_debug_commit  = commit;
    o_debug_pc      = '0;
    o_debug_dnpc    = '0;
    o_debug_inst    = '0;
    o_debug_memen   = 1'b0;
    o_debug_memaddr = '0;
    o_retire_cnt    = retire_cnt_q;
    o_ws_to_ds_bypass_bus = '0;
    if (ws_valid_q) begin
      o_debug_pc      = dbg_bus_q.pc;
      o_debug_dnpc    = dbg_bus_q.dnpc;
      o_debug_inst    = dbg_bus_q.inst;
      o_debug_memen   = dbg_bus_q.memen;
      o_debug_memaddr = dbg_bus_q.memaddr;
      // Result is final even while stalled, so decode may forward it.
      o_ws_to_ds_bypass_bus = {
        ms_bus_q.gpr_wen ? ms_bus_q.rd         : {GPR_ADDR_WD{1'b0}},
        ms_bus_q.gpr_wen ? ms_bus_q.gpr_result : {WORD_WD{1'b0}},
        ms_bus_q.csr_wen ? ms_bus_q.csr        : {CSR_ADDR_WD{1'b0}},
        ms_bus_q.csr_wen ? ms_bus_q.csr_result : {WORD_WD{1'b0}}
      };
    end
  end

endmodule
